// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares one split index/tag dcache request port among NR_PORTS requesters.
// Round-robin pick on the index phase, sticky lock while the cache withholds
// its grant, tag/kill steered from the last granted port one cycle later, and
// an in-order ID FIFO that routes every read return back to its originator.
module dcache_port_arbiter #(
  parameter int NR_PORTS = 3,
  parameter int DEPTH    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NR_PORTS*12-1:0] req_index_i,
  input  logic [NR_PORTS*44-1:0] req_tag_i,
  input  logic [NR_PORTS*64-1:0] req_wdata_i,
  input  logic [NR_PORTS-1:0]    req_we_i,
  input  logic [NR_PORTS*8-1:0]  req_be_i,
  input  logic [NR_PORTS-1:0]    req_valid_i,
  input  logic [NR_PORTS-1:0]    req_kill_i,
  input  logic [NR_PORTS-1:0]    req_tag_valid_i,
  output logic [NR_PORTS-1:0]    req_gnt_o,
  output logic [NR_PORTS-1:0]    req_rvalid_o,
  output logic [63:0]            req_rdata_o,
  output logic [11:0]            address_index_o,
  output logic [43:0]            address_tag_o,
  output logic [63:0]            data_wdata_o,
  output logic                   data_we_o,
  output logic [7:0]             data_be_o,
  output logic                   data_req_o,
  output logic                   kill_req_o,
  output logic                   tag_valid_o,
  input  logic                   data_gnt_i,
  input  logic                   data_rvalid_i,
  input  logic [63:0]            data_rdata_i,
  output logic                   err_o
);

  localparam int IDW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  // arbitration / tag state
  logic [IDW-1:0] rr_ptr;
  logic           locked_q;
  logic [IDW-1:0] lock_id_q;
  logic [IDW-1:0] tag_owner_q;
  logic           tag_pend_q;
  logic           err_r;

  // in-order ID FIFO
  logic [IDW-1:0] id_fifo_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  // combinational helpers
  logic [CW-1:0]       occupancy_s;
  logic                full_s;
  logic [NR_PORTS-1:0] valid_m_s;
  logic [IDW:0]        cand_s;
  logic                rr_hit_s;
  logic                rr_found_s;
  logic [IDW-1:0]      rr_pick_s;
  logic                lock_valid_raw_s;
  logic                lock_valid_m_s;
  logic [IDW-1:0]      winner_s;
  logic                grant_s;
  logic                push_s;
  logic                pop_s;
  logic                fifo_empty_s;
  logic [IDW-1:0]      head_id_s;
  logic                lock_drop_s;

  // Backpressure: tagged-outstanding plus a tag still in flight must leave room.
  always_comb begin
    occupancy_s = count_r + CW'(tag_pend_q);
    full_s      = (occupancy_s >= CW'(DEPTH));
    valid_m_s   = full_s ? '0 : req_valid_i;
  end

  // Round-robin search: first eligible port at or after rr_ptr, wrapping.
  always_comb begin
    rr_found_s = 1'b0;
    rr_pick_s  = '0;
    cand_s     = '0;
    rr_hit_s   = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand_s = {1'b0, rr_ptr} + (IDW+1)'(i);
      cand_s = (cand_s >= (IDW+1)'(NR_PORTS)) ? (cand_s - (IDW+1)'(NR_PORTS)) : cand_s;
      for (int p = 0; p < NR_PORTS; p++) begin
        rr_hit_s   = !rr_found_s && valid_m_s[p] && (cand_s == (IDW+1)'(p));
        rr_pick_s  = rr_hit_s ? IDW'(p) : rr_pick_s;
        rr_found_s = rr_found_s | rr_hit_s;
      end
    end
  end

  // Winner selection: a locked port overrides the round-robin result.
  always_comb begin
    lock_valid_raw_s = 1'b0;
    lock_valid_m_s   = 1'b0;
    for (int p = 0; p < NR_PORTS; p++) begin
      lock_valid_raw_s = lock_valid_raw_s | ((IDW'(p) == lock_id_q) && req_valid_i[p]);
      lock_valid_m_s   = lock_valid_m_s   | ((IDW'(p) == lock_id_q) && valid_m_s[p]);
    end
    winner_s    = locked_q ? lock_id_q : rr_pick_s;
    data_req_o  = locked_q ? lock_valid_m_s : rr_found_s;
    grant_s     = data_req_o && data_gnt_i;
    lock_drop_s = locked_q && !lock_valid_raw_s;
  end

  // Index-phase mux toward the cache and grant steering back to the winner.
  always_comb begin
    address_index_o = 12'd0;
    data_wdata_o    = 64'd0;
    data_we_o       = 1'b0;
    data_be_o       = 8'd0;
    req_gnt_o       = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      address_index_o = address_index_o | ((data_req_o && (IDW'(p) == winner_s)) ? req_index_i[p*12 +: 12] : 12'd0);
      data_wdata_o    = data_wdata_o    | ((data_req_o && (IDW'(p) == winner_s)) ? req_wdata_i[p*64 +: 64] : 64'd0);
      data_we_o       = data_we_o       | (data_req_o && (IDW'(p) == winner_s) && req_we_i[p]);
      data_be_o       = data_be_o       | ((data_req_o && (IDW'(p) == winner_s)) ? req_be_i[p*8 +: 8] : 8'd0);
      req_gnt_o[p]    = data_req_o && (IDW'(p) == winner_s) && data_gnt_i;
    end
  end

  // Tag-phase mux from the port granted in the previous cycle.
  always_comb begin
    address_tag_o = 44'd0;
    tag_valid_o   = 1'b0;
    kill_req_o    = 1'b0;
    for (int p = 0; p < NR_PORTS; p++) begin
      address_tag_o = address_tag_o | ((tag_pend_q && (IDW'(p) == tag_owner_q)) ? req_tag_i[p*44 +: 44] : 44'd0);
      tag_valid_o   = tag_valid_o   | (tag_pend_q && (IDW'(p) == tag_owner_q) && req_tag_valid_i[p]);
      kill_req_o    = kill_req_o    | (tag_pend_q && (IDW'(p) == tag_owner_q) && req_kill_i[p]);
    end
    push_s = tag_valid_o && !kill_req_o;
  end

  // Return routing: the FIFO head owns the current data_rvalid_i.
  always_comb begin
    fifo_empty_s = (count_r == CW'(0));
    head_id_s    = id_fifo_r[rd_ptr_r];
    pop_s        = data_rvalid_i && !fifo_empty_s;
    req_rdata_o  = data_rdata_i;
    for (int p = 0; p < NR_PORTS; p++) begin
      req_rvalid_o[p] = pop_s && (IDW'(p) == head_id_s);
    end
  end

  // Lock and round-robin pointer update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr    <= '0;
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else if (lock_drop_s) begin
      locked_q  <= 1'b0;
    end else if (grant_s) begin
      locked_q  <= 1'b0;
      rr_ptr    <= (winner_s == IDW'(NR_PORTS-1)) ? '0 : (winner_s + IDW'(1));
    end else if (data_req_o) begin
      locked_q  <= 1'b1;
      lock_id_q <= winner_s;
    end else begin
      locked_q  <= locked_q;
    end
  end

  // Tag phase follows every grant by exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_pend_q  <= 1'b0;
      tag_owner_q <= '0;
    end else if (grant_s) begin
      tag_pend_q  <= 1'b1;
      tag_owner_q <= winner_s;
    end else begin
      tag_pend_q  <= 1'b0;
    end
  end

  // ID FIFO storage and pointers; push and pop may coincide even when full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_fifo_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        id_fifo_r[wr_ptr_r] <= tag_owner_q;
        wr_ptr_r            <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky protocol error: lock abandoned before grant, or return with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | lock_drop_s | (data_rvalid_i && fifo_empty_s);
    end
  end

  assign err_o = err_r;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a stimulus process drives one
// cycle at a time and pushes the expected outputs computed by a queue-based
// reference model; a monitor pops and compares on every falling edge.
module tb_dcache_port_arbiter;

  localparam int NP = 3;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NP*12-1:0]  req_index = '0;
  logic [NP*44-1:0]  req_tag = '0;
  logic [NP*64-1:0]  req_wdata = '0;
  logic [NP-1:0]     req_we = '0;
  logic [NP*8-1:0]   req_be = '0;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_kill = '0;
  logic [NP-1:0]     req_tag_valid = '0;
  logic [NP-1:0]     req_gnt;
  logic [NP-1:0]     req_rvalid;
  logic [63:0]       req_rdata;
  logic [11:0]       address_index;
  logic [43:0]       address_tag;
  logic [63:0]       data_wdata;
  logic              data_we;
  logic [7:0]        data_be;
  logic              data_req;
  logic              kill_req;
  logic              tag_valid;
  logic              data_gnt = 1'b0;
  logic              data_rvalid = 1'b0;
  logic [63:0]       data_rdata = '0;
  logic              err;

  dcache_port_arbiter #(.NR_PORTS(NP), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_index_i(req_index), .req_tag_i(req_tag), .req_wdata_i(req_wdata),
    .req_we_i(req_we), .req_be_i(req_be), .req_valid_i(req_valid),
    .req_kill_i(req_kill), .req_tag_valid_i(req_tag_valid),
    .req_gnt_o(req_gnt), .req_rvalid_o(req_rvalid), .req_rdata_o(req_rdata),
    .address_index_o(address_index), .address_tag_o(address_tag),
    .data_wdata_o(data_wdata), .data_we_o(data_we), .data_be_o(data_be),
    .data_req_o(data_req), .kill_req_o(kill_req), .tag_valid_o(tag_valid),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] gnt;
    logic [NP-1:0] rvalid;
    logic [63:0]   rdata;
    logic          req;
    logic [11:0]   idx;
    logic [63:0]   wdata;
    logic          we;
    logic [7:0]    be;
    logic [43:0]   tag;
    logic          tv;
    logic          kill;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int   m_rr, m_lock_id, m_owner;
  bit   m_locked, m_pend, m_err;
  int   m_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // monitor: one expectation per cycle, compared away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_gnt", 64'(req_gnt), 64'(e.gnt));
      chk("req_rvalid", 64'(req_rvalid), 64'(e.rvalid));
      chk("req_rdata", req_rdata, e.rdata);
      chk("data_req", 64'(data_req), 64'(e.req));
      chk("address_index", 64'(address_index), 64'(e.idx));
      chk("data_wdata", data_wdata, e.wdata);
      chk("data_we", 64'(data_we), 64'(e.we));
      chk("data_be", 64'(data_be), 64'(e.be));
      chk("address_tag", 64'(address_tag), 64'(e.tag));
      chk("tag_valid", 64'(tag_valid), 64'(e.tv));
      chk("kill_req", 64'(kill_req), 64'(e.kill));
      chk("err", 64'(err), 64'(e.err));
    end
  end

  task automatic model_reset();
    m_rr = 0; m_lock_id = 0; m_owner = 0;
    m_locked = 0; m_pend = 0; m_err = 0;
    m_q.delete();
  endtask

  // One clock cycle: drive inputs just after the rising edge, predict, advance model.
  task automatic step(input logic [NP-1:0] v, input logic g, input logic [NP-1:0] tv,
                      input logic [NP-1:0] kl, input logic rv, input logic [63:0] rd);
    exp_t e;
    logic [63:0] r64;
    int   w;
    int   p;
    bit   req, blocked;
    for (int i = 0; i < NP; i++) begin
      req_index[i*12 +: 12] = 12'($urandom);
      r64 = {$urandom, $urandom};
      req_tag[i*44 +: 44] = r64[43:0];
      req_wdata[i*64 +: 64] = {$urandom, $urandom};
      req_we[i] = 1'($urandom);
      req_be[i*8 +: 8] = 8'($urandom);
    end
    req_valid = v; data_gnt = g; req_tag_valid = tv; req_kill = kl;
    data_rvalid = rv; data_rdata = rd;

    blocked = (m_q.size() + int'(m_pend)) >= DP;
    req = 0; w = 0;
    if (m_locked) begin
      w = m_lock_id;
      req = v[w] && !blocked;
    end else begin
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (!req && v[p] && !blocked) begin
          req = 1; w = p;
        end
      end
    end
    e.req    = req;
    e.gnt    = (req && g) ? NP'(1 << w) : '0;
    e.idx    = req ? req_index[w*12 +: 12] : 12'd0;
    e.wdata  = req ? req_wdata[w*64 +: 64] : 64'd0;
    e.we     = req ? req_we[w] : 1'b0;
    e.be     = req ? req_be[w*8 +: 8] : 8'd0;
    e.tag    = m_pend ? req_tag[m_owner*44 +: 44] : 44'd0;
    e.tv     = m_pend && tv[m_owner];
    e.kill   = m_pend && kl[m_owner];
    e.rvalid = (rv && m_q.size() > 0) ? NP'(1 << m_q[0]) : '0;
    e.rdata  = rd;
    e.err    = m_err;
    exp_q.push_back(e);

    if (rv) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (m_pend && tv[m_owner] && !kl[m_owner]) m_q.push_back(m_owner);
    if (m_locked && !v[m_lock_id]) begin
      m_locked = 0; m_err = 1; m_pend = 0;
    end else if (req && g) begin
      m_locked = 0; m_rr = (w + 1) % NP; m_pend = 1; m_owner = w;
    end else begin
      if (req) begin m_locked = 1; m_lock_id = w; end
      m_pend = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst_ni = 1'b0;
    req_valid = '0; data_gnt = 1'b0; req_tag_valid = '0; req_kill = '0;
    data_rvalid = 1'b0; data_rdata = '0; req_index = '0; req_tag = '0;
    req_wdata = '0; req_we = '0; req_be = '0;
    model_reset();
    e = '{gnt: '0, rvalid: '0, rdata: 64'd0, req: 1'b0, idx: 12'd0, wdata: 64'd0,
          we: 1'b0, be: 8'd0, tag: 44'd0, tv: 1'b0, kill: 1'b0, err: 1'b0};
    exp_q.push_back(e);
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] v;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // single port 0 read, return four cycles after the grant
    step(3'b001, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 64'h0000_0000_DEAD_BEEF);

    // fairness: all request, immediate grant
    do_reset();
    repeat (6) step(3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);

    // lock: port 2 held against port 0 while grant is withheld
    do_reset();
    step(3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b101, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b101, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b101, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b101, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);

    // kill in the tag cycle, then backpressure at DEPTH outstanding
    do_reset();
    step(3'b010, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b010, 3'b010, 1'b0, 64'd0);
    repeat (6) step(3'b001, 1'b1, 3'b111, 3'b000, 1'b0, 64'd0);
    step(3'b001, 1'b1, 3'b000, 3'b000, 1'b1, {$urandom, $urandom});
    step(3'b001, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);

    // randomized traffic; a locked port keeps requesting so err stays clear
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = NP'($urandom);
      if (m_locked) v[m_lock_id] = 1'b1;
      step(v, 1'($urandom_range(0, 1)), NP'($urandom_range(0, 7) | $urandom_range(0, 7)),
           NP'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7)),
           (m_q.size() > 0) && ($urandom_range(0, 9) < 4), {$urandom, $urandom});
    end

    // return with empty FIFO: sticky error
    do_reset();
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 64'h1234);
    repeat (3) step(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);

    // locked port abandons its request before grant
    do_reset();
    step(3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);

    // reset mid-transaction drops outstanding IDs
    do_reset();
    step(3'b010, 1'b1, 3'b000, 3'b000, 1'b0, 64'd0);
    step(3'b000, 1'b0, 3'b010, 3'b000, 1'b0, 64'd0);
    do_reset();
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 64'h55);
    step(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 64'd0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares one data-cache request port (split index/tag protocol with kill, grant and in-order read-valid) among `NR_PORTS` requesters such as load unit, store unit and PTW. Round-robin arbitration runs on the index phase, the tag/kill phase is steered from the previously granted requester, and an in-order ID FIFO routes each `data_rvalid`/`data_rdata` back to its originator. The block sits between the core's memory-access units and the dcache, on the core side of `dcache_if`.

## Interface

- `NR_PORTS`, 3: number of requesters, 2..8.
- `DEPTH`, 4: maximum outstanding (tagged, not yet returned) transactions, power of two, ≥2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  async active-low reset.
- `req_index_i`  in  NR_PORTS×12  per-port index.
- `req_tag_i`  in  NR_PORTS×44  per-port tag.
- `req_wdata_i`  in  NR_PORTS×64  per-port write data.
- `req_we_i` / `req_be_i`  in  NR_PORTS×1 / NR_PORTS×8  write enable, byte enable.
- `req_valid_i`  in  NR_PORTS  per-port `data_req`.
- `req_kill_i` / `req_tag_valid_i`  in  NR_PORTS each  per-port kill and tag-valid.
- `req_gnt_o`  out  NR_PORTS  one-hot grant.
- `req_rvalid_o`  out  NR_PORTS  one-hot return valid.
- `req_rdata_o`  out  64  return data, broadcast.
- `address_index_o`, `address_tag_o`, `data_wdata_o`, `data_we_o`, `data_be_o`, `data_req_o`, `kill_req_o`, `tag_valid_o`  out  12/44/64/1/8/1/1/1  to dcache.
- `data_gnt_i`, `data_rvalid_i`  in  1 each; `data_rdata_i`  in  64  from dcache.
- `err_o`  out  1  sticky protocol error.

## Operation

- Arbitration: among ports with `req_valid_i`, pick the first at or after `rr_ptr` (wrapping). Winner's index, wdata, we and be drive the cache; `data_req_o` = any eligible request.
- Lock: once a winner has driven `data_req_o` without `data_gnt_i`, the winner is held (`locked_q`, `lock_id_q`) until granted, even if higher-priority ports appear. If the locked port drops `req_valid_i` before grant, release the lock and set `err_o`.
- Grant: `req_gnt_o[winner]` = `data_gnt_i`. On grant, `rr_ptr` ← winner+1 mod NR_PORTS, `tag_owner_q` ← winner, `tag_pend_q` ← 1.
- Tag phase: the cycle after a grant. `address_tag_o`, `tag_valid_o` and `kill_req_o` are muxed from `tag_owner_q` when `tag_pend_q`, else 0. `tag_pend_q` clears unless a new grant occurs in the same cycle. Index phase of a new request and tag phase of the previous one may overlap.
- ID FIFO: push `tag_owner_q` when `tag_pend_q && tag_valid && !kill`. Killed requests, or no tag-valid in the tag cycle, return nothing and are not pushed.
- Return: on `data_rvalid_i`, assert `req_rvalid_o[fifo head]` and pop. `req_rdata_o` = `data_rdata_i` combinationally. `data_rvalid_i` with an empty FIFO sets `err_o` and routes nowhere.
- Backpressure: if `count + tag_pend_q ≥ DEPTH`, mask all `req_valid_i`, so `data_req_o` = 0. A locked request stays locked with `data_req_o` deasserted.
- Simultaneous push and pop: count unchanged. Pop and push in the same cycle are legal even when full.

## Timing

- Combinational paths: `req_valid_i` → `data_req_o`; `data_gnt_i` → `req_gnt_o`; `data_rvalid_i` → `req_rvalid_o`.
- Tag is issued exactly one cycle after grant. Return latency is set by the cache; the arbiter adds 0 cycles.
- Reset, asynchronous, state cleared: `rr_ptr` = 0, `locked_q` = 0, `tag_pend_q` = 0, FIFO empty, `err_o` = 0.
- Outputs immediately after reset: all cache-side and requester-side outputs = 0.
- Reset mid-transaction: outstanding IDs are dropped. Any later `data_rvalid_i` sets `err_o`.

## Test plan

- Single port 0 read: grant at t, tag_valid at t+1, cache rvalid at t+4 with data 0xDEAD_BEEF → `req_rvalid_o` = 3'b001, `req_rdata_o` = 0xDEAD_BEEF.
- Fairness: ports 0, 1 and 2 request continuously with immediate gnt → grants cycle 0,1,2,0,1,2 and no port is starved.
- Lock: port 2 requests, gnt withheld 3 cycles while port 0 also requests → port 2 is held and granted first; `rr_ptr` then = 0.
- Kill: port 1 is granted, then `kill_req` in the tag cycle → FIFO count stays 0 and no `req_rvalid_o[1]`.
- Backpressure: DEPTH = 4 reads tagged with no return → 5th `data_req_o` = 0; one rvalid → request resumes next cycle.
- Protocol error: `data_rvalid_i` with empty FIFO → `err_o` = 1 and stays set until reset.
